// File: rtl/axi_burst_len_ctrl_pkg.sv
// Shared types for the burst-length controller.
// Provides the AXI length encoding and a default request/response struct
// pair used when the controller is instantiated without project-specific
// AXI types. Only the handshake fields and r.last are interpreted by the
// controller; every other field is passed through untouched.
package axi_burst_len_ctrl_pkg;

    typedef logic [7:0] len_t;

    typedef struct packed {
        logic [31:0] addr;
        len_t        len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } dflt_axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        r_chan_t  r;
        logic     r_valid;
    } dflt_axi_resp_t;

endpackage

// File: rtl/axi_burst_len_ctrl_txn_cnt.sv
// Outstanding-burst counter.
// Saturating up/down counter sized to hold 0..MaxTxns.
//   clk_i/rst_i : clock, synchronous active-high reset
//   inc_i       : burst issued (address handshake)
//   dec_i       : burst retired (B or last R handshake)
//   full_o      : count == MaxTxns
//   empty_o     : count == 0
// A simultaneous inc/dec leaves the count unchanged. A decrement at zero is
// a protocol violation: it is flagged and the count holds at zero.
module axi_burst_len_ctrl_txn_cnt #(
    parameter int unsigned MaxTxns = 32'd8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CntW = $clog2(MaxTxns + 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    assign full_o  = (cnt_q == CntW'(MaxTxns));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            assert (!(dec_i && !inc_i && empty_o))
                else $error("txn counter underflow");
        end
    end

endmodule

// File: rtl/axi_burst_len_ctrl.sv
// Runtime controller for the burst splitter's length limit.
// Passes AXI traffic through and owns the registered len_limit_o. A new
// limit is applied only once every outstanding read and write burst has
// retired, so the splitter never sees the limit move mid-burst.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   cfg_len_i/valid/ready     : new-limit request handshake
//   busy_o                    : a limit change is in progress
//   len_limit_o               : to splitter len_limit_i
//   slv_req_i / slv_resp_o    : upstream AXI port
//   mst_req_o / mst_resp_i    : port toward the splitter
module axi_burst_len_ctrl
    import axi_burst_len_ctrl_pkg::*;
#(
    parameter int unsigned MaxReadTxns  = 32'd8,
    parameter int unsigned MaxWriteTxns = 32'd8,
    parameter logic [7:0]  ResetLen     = 8'h00,
    parameter type         axi_req_t    = dflt_axi_req_t,
    parameter type         axi_resp_t   = dflt_axi_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cfg_len_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    output logic       busy_o,
    output logic [7:0] len_limit_o,
    input  axi_req_t   slv_req_i,
    output axi_resp_t  slv_resp_o,
    output axi_req_t   mst_req_o,
    input  axi_resp_t  mst_resp_i
);

    typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_e;

    state_e state_d, state_q;
    len_t   pend_d, pend_q;
    len_t   len_limit_d, len_limit_q;

    logic wr_full, wr_empty, rd_full, rd_empty;
    logic aw_gate, ar_gate;
    logic aw_hs, b_hs, ar_hs, r_last_hs;

    // Address channels are closed during reset, throughout a change, and
    // whenever the matching counter has no room for another burst.
    assign aw_gate = rst_i || (state_q != RUN) || wr_full;
    assign ar_gate = rst_i || (state_q != RUN) || rd_full;

    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;
        if (aw_gate) begin
            mst_req_o.aw_valid  = 1'b0;
            slv_resp_o.aw_ready = 1'b0;
        end
        if (ar_gate) begin
            mst_req_o.ar_valid  = 1'b0;
            slv_resp_o.ar_ready = 1'b0;
        end
    end

    // Handshakes are observed on the splitter side, after gating.
    assign aw_hs     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign ar_hs     = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    axi_burst_len_ctrl_txn_cnt #(.MaxTxns(MaxWriteTxns)) i_wr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (aw_hs),
        .dec_i   (b_hs),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    axi_burst_len_ctrl_txn_cnt #(.MaxTxns(MaxReadTxns)) i_rd_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ar_hs),
        .dec_i   (r_last_hs),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    assign cfg_ready_o = !rst_i && (state_q == RUN);
    assign busy_o      = !rst_i && (state_q != RUN);
    assign len_limit_o = len_limit_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        len_limit_d = len_limit_q;
        unique case (state_q)
            RUN: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    pend_d  = cfg_len_i;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_empty && rd_empty) begin
                    len_limit_d = pend_q;
                    state_d     = APPLY;
                end
            end
            // One gated cycle so the splitter holds the new limit before the
            // first address of the new regime arrives.
            APPLY: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            pend_q      <= '0;
            len_limit_q <= ResetLen;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            len_limit_q <= len_limit_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_len_ctrl.sv
module tb_axi_burst_len_ctrl;
    import axi_burst_len_ctrl_pkg::*;

    localparam int unsigned MAXW      = 2;
    localparam int unsigned MAXR      = 4;
    localparam logic [7:0]  RESET_LEN = 8'h0F;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     cfg_len;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           busy;
    logic [7:0]     len_limit;
    dflt_axi_req_t  slv_req, mst_req;
    dflt_axi_resp_t slv_resp, mst_resp;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding burst counts and the pending change.
    int         m_wr, m_rd;
    bit         m_pending, m_apply;
    logic [7:0] m_limit, m_pend;

    always #5 clk = ~clk;

    axi_burst_len_ctrl #(
        .MaxReadTxns (MAXR),
        .MaxWriteTxns(MAXW),
        .ResetLen    (RESET_LEN),
        .axi_req_t   (dflt_axi_req_t),
        .axi_resp_t  (dflt_axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_len_i  (cfg_len),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .busy_o     (busy),
        .len_limit_o(len_limit),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then
    // advance the model with the handshakes it predicts for this cycle.
    task automatic cycle();
        logic exp_busy, aw_ok, ar_ok, aw_hs, ar_hs, b_hs, r_hs, cfg_hs;
        #4;
        exp_busy = !rst && (m_pending || m_apply);
        aw_ok    = !rst && !exp_busy && (m_wr < MAXW);
        ar_ok    = !rst && !exp_busy && (m_rd < MAXR);
        chk("cfg_ready", cfg_ready, !rst && !exp_busy);
        chk("busy", busy, exp_busy);
        chk("len_limit", len_limit, m_limit);
        chk("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && aw_ok);
        chk("slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && aw_ok);
        chk("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && ar_ok);
        chk("slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && ar_ok);
        chk("pass_aw_addr", mst_req.aw.addr, slv_req.aw.addr);
        chk("pass_b_valid", slv_resp.b_valid, mst_resp.b_valid);
        chk("pass_r_valid", slv_resp.r_valid, mst_resp.r_valid);
        aw_hs  = slv_req.aw_valid && mst_resp.aw_ready && aw_ok;
        ar_hs  = slv_req.ar_valid && mst_resp.ar_ready && ar_ok;
        b_hs   = mst_resp.b_valid && slv_req.b_ready;
        r_hs   = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
        cfg_hs = cfg_valid && !rst && !exp_busy;
        @(posedge clk);
        if (rst) begin
            m_wr = 0; m_rd = 0; m_pending = 0; m_apply = 0; m_limit = RESET_LEN;
        end else begin
            if (cfg_hs) begin
                m_pending = 1; m_pend = cfg_len;
            end else if (m_pending && m_wr == 0 && m_rd == 0) begin
                m_limit = m_pend; m_pending = 0; m_apply = 1;
            end else if (m_apply) begin
                m_apply = 0;
            end
            m_wr = m_wr + int'(aw_hs) - int'(b_hs);
            m_rd = m_rd + int'(ar_hs) - int'(r_hs);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; cfg_len = '0; cfg_valid = 1'b0;
        slv_req = '0; mst_resp = '0;
        m_wr = 0; m_rd = 0; m_pending = 0; m_apply = 0; m_limit = RESET_LEN; m_pend = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with upstream trying to issue addresses.
        slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
        mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
        idle(2);
        chk("rst_len", len_limit, RESET_LEN);
        slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
        rst = 1'b0;

        // Idle bus: cfg 3 accepted at cycle 10.
        idle(10);
        cfg_valid = 1'b1; cfg_len = 8'h03;
        cycle();
        cfg_valid = 1'b0;
        chk("t1_busy_c11", busy, 1'b1);
        chk("t1_len_c11", len_limit, RESET_LEN);
        cycle();
        chk("t1_busy_c12", busy, 1'b1);
        chk("t1_len_c12", len_limit, 8'h03);
        cycle();
        chk("t1_ready_c13", cfg_ready, 1'b1);
        idle(2);

        // Two writes outstanding, then cfg 1; AW held until both Bs.
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h1000;
        idle(2);
        cfg_valid = 1'b1; cfg_len = 8'h01;
        cycle();
        cfg_valid = 1'b0;
        idle(3);
        slv_req.b_ready = 1'b1; mst_resp.b_valid = 1'b1;
        cycle();
        mst_resp.b_valid = 1'b0;
        idle(2);
        chk("t2_len_hold", len_limit, 8'h03);
        mst_resp.b_valid = 1'b1;
        cycle();
        mst_resp.b_valid = 1'b0; slv_req.aw_valid = 1'b0;
        chk("t2_len_after_b2", len_limit, 8'h03);
        cycle();
        chk("t2_len_new", len_limit, 8'h01);
        idle(2);

        // Three reads of len 7; only r.last retires a burst.
        slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'h07;
        idle(3);
        slv_req.ar_valid = 1'b0;
        cfg_valid = 1'b1; cfg_len = 8'h02;
        cycle();
        cfg_valid = 1'b0;
        slv_req.r_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int beat = 0; beat < 8; beat++) begin
                mst_resp.r_valid = 1'b1; mst_resp.r.last = (beat == 7);
                cycle();
            end
            if (b < 2) chk("t3_still_busy", busy, 1'b1);
        end
        mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
        chk("t3_len_before", len_limit, 8'h01);
        cycle();
        chk("t3_len_after", len_limit, 8'h02);
        idle(2);

        // Write counter full at 2; B plus AW in one cycle keeps the count.
        slv_req.aw_valid = 1'b1;
        idle(3);
        chk("t4_aw_stall", slv_resp.aw_ready, 1'b0);
        mst_resp.b_valid = 1'b1;
        cycle();
        cycle();
        mst_resp.b_valid = 1'b0;
        cycle();
        #1;
        chk("t4_full_again", slv_resp.aw_ready, 1'b0);
        #0;
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        idle(2);
        mst_resp.b_valid = 1'b0;
        idle(1);

        // Reset during DRAIN with pending 5: the change is dropped.
        slv_req.aw_valid = 1'b1;
        cycle();
        slv_req.aw_valid = 1'b0;
        cfg_valid = 1'b1; cfg_len = 8'h05;
        cycle();
        cfg_valid = 1'b0;
        idle(2);
        chk("t5_draining", busy, 1'b1);
        rst = 1'b1;
        cycle();
        chk("t5_rst_len", len_limit, RESET_LEN);
        chk("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);
        chk("t5_no_apply", len_limit, RESET_LEN);
        slv_req.aw_valid = 1'b1;
        idle(2);
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        idle(2);
        mst_resp.b_valid = 1'b0;

        // Random traffic with random cfg requests.
        for (int i = 0; i < 800; i++) begin
            slv_req.aw_valid  = ($urandom_range(0, 1) == 1);
            slv_req.aw.addr   = $urandom;
            slv_req.ar_valid  = ($urandom_range(0, 1) == 1);
            slv_req.ar.addr   = $urandom;
            slv_req.w_valid   = ($urandom_range(0, 1) == 1);
            slv_req.b_ready   = ($urandom_range(0, 1) == 1);
            slv_req.r_ready   = ($urandom_range(0, 1) == 1);
            mst_resp.aw_ready = ($urandom_range(0, 1) == 1);
            mst_resp.ar_ready = ($urandom_range(0, 1) == 1);
            mst_resp.b_valid  = (m_wr > 0) && ($urandom_range(0, 2) == 0);
            mst_resp.r_valid  = (m_rd > 0) && ($urandom_range(0, 1) == 1);
            mst_resp.r.last   = ($urandom_range(0, 2) == 0);
            cfg_valid         = ($urandom_range(0, 9) == 0);
            cfg_len           = 8'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
